// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment display capture block.
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_NIBBLE = 4'hF;

    // Per-scan capture FSM states.
    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } cap_state_t;

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational decode of an active-low segment pattern back to BCD.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_legal
);

    // Map each legal pattern to its nibble; anything else is flagged illegal.
    always_comb begin
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_legal = 1'b1;
        case (pattern)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: begin
                nibble   = BLANK_NIBBLE;
                is_blank = 1'b1;
            end
            default:   is_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed active-low 7-segment display, waits for each digit
// to settle, decodes it and publishes complete 4-digit frames.
//
// Output strobes: frame_valid is a one-cycle pulse with no back-pressure;
// digits/blank_mask change only on the edge that raises frame_valid and hold
// until the next frame. code_err is an independent one-cycle pulse.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FRAME_TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  blank_mask,
    output logic        frame_valid,
    output logic        code_err,
    output logic        stale
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    // Acceptance fires on the edge where the counter would reach STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
    localparam int TO_W = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(FRAME_TIMEOUT);

    logic [6:0]       seg_m, seg_s, seg_p;
    logic [3:0]       an_m, an_s, an_p;
    logic             changed, an_onehot;
    cap_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept;
    logic [3:0]       dec_nibble;
    logic             dec_blank, dec_legal;
    logic [15:0]      shd_d, shd_d_nx;
    logic [3:0]       shd_b, shd_b_nx;
    logic [3:0]       seen, seen_nx;
    logic             frame_done, bad_code;
    logic [TO_W-1:0]  to_cnt;

    // Two-flop synchronizer plus a copy of the previous synchronized value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_m <= '0; seg_s <= '0; seg_p <= '0;
            an_m  <= '0; an_s  <= '0; an_p  <= '0;
        end else begin
            seg_m <= seg;   seg_s <= seg_m; seg_p <= seg_s;
            an_m  <= an;    an_s  <= an_m;  an_p  <= an_s;
        end
    end

    assign changed = ({an_s, seg_s} != {an_p, seg_p});

    // Exactly one anode driven low selects a single digit slot.
    always_comb begin
        case (an_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_onehot = 1'b1;
            default:                            an_onehot = 1'b0;
        endcase
    end

    seg_pattern_decode u_decode (
        .pattern  (seg_s),
        .nibble   (dec_nibble),
        .is_blank (dec_blank),
        .is_legal (dec_legal)
    );

    // FSM state and stability counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: settle on a one-hot digit, accept once, then hold until it changes.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        case (state)
            WAIT: begin
                cnt_nx = '0;
                if (an_onehot) state_nx = SETTLE;
            end
            SETTLE: begin
                if (!an_onehot) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end else if (changed) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    accept   = 1'b1;
                    state_nx = HELD;
                    cnt_nx   = cnt + 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            HELD: begin
                if (changed) begin
                    cnt_nx   = '0;
                    state_nx = an_onehot ? SETTLE : WAIT;
                end
            end
            default: begin
                state_nx = WAIT;
                cnt_nx   = '0;
            end
        endcase
    end

    // Shadow write, seen-mask tracking and frame completion for an accepted digit.
    always_comb begin
        shd_d_nx   = shd_d;
        shd_b_nx   = shd_b;
        seen_nx    = seen;
        frame_done = 1'b0;
        bad_code   = 1'b0;
        if (accept) begin
            if (dec_legal) begin
                for (int i = 0; i < 4; i++) begin
                    if (!an_s[i]) begin
                        shd_d_nx[i*4 +: 4] = dec_nibble;
                        shd_b_nx[i]        = dec_blank;
                    end
                end
                seen_nx = seen | ~an_s;
                if (seen_nx == 4'b1111) begin
                    frame_done = 1'b1;
                    seen_nx    = 4'b0000;
                end
            end else begin
                bad_code = 1'b1;
                seen_nx  = 4'b0000;
            end
        end
    end

    // Shadow, seen-mask, published frame and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shd_d       <= '0;
            shd_b       <= '0;
            seen        <= '0;
            digits      <= '0;
            blank_mask  <= '0;
            frame_valid <= 1'b0;
            code_err    <= 1'b0;
        end else begin
            shd_d       <= shd_d_nx;
            shd_b       <= shd_b_nx;
            seen        <= seen_nx;
            frame_valid <= frame_done;
            code_err    <= bad_code;
            if (frame_done) begin
                digits     <= shd_d_nx;
                blank_mask <= shd_b_nx;
            end
        end
    end

    // Saturating count of cycles since the last frame; a new frame wins over saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (frame_done) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign stale = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: drives multiplexed digit scans and checks the
// captured frames against an expected queue.
module tb_seven_seg_capture;

    localparam int STABLE = 16;
    localparam int TMO    = 1000;
    localparam int WIN    = 40;

    logic        clk;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic        frame_valid;
    logic        code_err;
    logic        stale;

    logic [19:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          err_seen = 0;
    int          exp_err  = 0;

    seven_seg_capture #(
        .STABLE_CYCLES (STABLE),
        .FRAME_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .digits      (digits),
        .blank_mask  (blank_mask),
        .frame_valid (frame_valid),
        .code_err    (code_err),
        .stale       (stale)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0: enc = 7'b1000000;
            4'd1: enc = 7'b1111001;
            4'd2: enc = 7'b0100100;
            4'd3: enc = 7'b0110000;
            4'd4: enc = 7'b0011001;
            4'd5: enc = 7'b0010010;
            4'd6: enc = 7'b0000010;
            4'd7: enc = 7'b1111000;
            4'd8: enc = 7'b0000000;
            4'd9: enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    task automatic send_digit(input int slot, input logic [6:0] pat, input int cycles);
        @(negedge clk);
        an  = ~(4'b0001 << slot);
        seg = pat;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] d);
        logic [3:0] bm;
        for (int s = 0; s < 4; s++) bm[s] = (d[s*4 +: 4] == 4'hF);
        exp_q.push_back({bm, d});
        for (int s = 3; s >= 0; s--) send_digit(s, enc(d[s*4 +: 4]), WIN);
    endtask

    task automatic idle(input int cycles);
        @(negedge clk);
        an  = 4'b1111;
        seg = 7'b1111111;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        an  = 4'b1111;
        seg = 7'b1111111;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: pop and compare on every frame strobe; count error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", {12'h0, blank_mask, digits}, 32'hFFFFFFFF);
                end else begin
                    check("frame", {12'h0, blank_mask, digits}, {12'h0, exp_q.pop_front()});
                    check("stale_at_frame", stale, 0);
                end
            end
            if (code_err) err_seen++;
        end
    end

    initial begin
        rst = 1'b1;
        an  = 4'b1111;
        seg = 7'b1111111;
        #100;
        check("rst_digits", digits, 0);
        check("rst_frame_valid", frame_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_digits", digits, 16'h0000);
        check("reset_blank", blank_mask, 0);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_code_err", code_err, 0);
        check("reset_stale", stale, 0);

        // Plain frame 1,2,3,4.
        send_frame(16'h1234);
        wait_drain("drain_1234");

        // Short glitch of an '8' pattern inside digit 2's window.
        exp_q.push_back({4'b0000, 16'h1234});
        send_digit(3, enc(4'd1), WIN);
        send_digit(2, enc(4'd2), 10);
        send_digit(2, 7'b0000000, 8);
        send_digit(2, enc(4'd2), 30);
        send_digit(1, enc(4'd3), WIN);
        send_digit(0, enc(4'd4), WIN);
        wait_drain("drain_glitch");
        check("glitch_no_code_err", err_seen, exp_err);
        check("glitch_digits", digits, 16'h1234);

        // Blank leading digit.
        send_frame(16'hF059);
        wait_drain("drain_blank");

        // Illegal pattern clears partial progress on slots 1,0.
        send_digit(1, enc(4'd1), WIN);
        send_digit(0, enc(4'd2), WIN);
        send_digit(3, 7'b0110110, WIN);
        exp_err++;
        check("illegal_code_err", err_seen, exp_err);
        send_frame(16'h5678);
        wait_drain("drain_after_illegal");

        // Reset after two digits discards them.
        send_digit(1, enc(4'd9), WIN);
        send_digit(0, enc(4'd8), WIN);
        pulse_reset();
        repeat (2) @(negedge clk);
        check("midrst_digits", digits, 16'h0000);
        check("midrst_blank", blank_mask, 0);
        send_frame(16'h4321);
        wait_drain("drain_after_midrst");

        // Stale boundary with no anode active.
        @(negedge clk);
        an  = 4'b1111;
        seg = 7'b1111111;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (TMO - 1) @(posedge clk);
        #1 check("stale_before_limit", stale, 0);
        @(posedge clk);
        #1 check("stale_at_limit", stale, 1);
        repeat (50) @(negedge clk);
        check("stale_held", stale, 1);
        send_frame(16'h0907);
        wait_drain("drain_after_stale");
        check("stale_cleared", stale, 0);

        idle(5);
        check("final_code_err", err_seen, exp_err);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
